deser_shift_rx: RTL and testbench
=================================

Name: deser_shift_rx

Overview:
- Serial-in, parallel-out receiver. It is the receive end of the serial link fed by the team's universal shift register.
- Accepts one bit per qualified cycle and assembles N-bit words, MSB-first or LSB-first.
- Delivers each completed word through a valid/ready output buffer.
- Flags overrun when a completed word cannot be buffered.

Parameters:
N, 4, word width in bits; legal range N >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
sin  input  1  serial data bit
sin_valid  input  1  sin is a valid bit this cycle; cycles with sin_valid=0 are ignored (gaps allowed)
msb_first  input  1  1 = first received bit ends in q[N-1]; 0 = first bit ends in q[0]
sync  input  1  frame alignment: discard any partial word, restart bit count
q  output  N  received word
q_valid  output  1  q holds an undelivered word
q_ready  input  1  consumer accepts q when q_valid && q_ready
overrun  output  1  sticky: a completed word was dropped
clr_ovr  input  1  clears overrun

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high.
  - On a rising edge with rst=1: sr=0, cnt=0, mode=0, q=0, q_valid=0, overrun=0.
  - rst overrides all other inputs, including mid-word and with q_valid=1; the partial word and any buffered word are lost.
- Internal state:
  - sr: N-bit shift register.
  - cnt: bit counter, 0..N-1, width clog2(N).
  - mode: msb_first value latched for the current word.
  - Output buffer: q plus q_valid.
- Receive FSM, two states:
  - IDLE (cnt==0, no partial word).
  - ACTIVE (1 <= cnt <= N-1).
  - IDLE -> ACTIVE on an accepted bit when N > 1.
  - ACTIVE -> IDLE on the N-th bit or on sync.
- Bit acceptance (sin_valid=1):
  - mode=1: sr <= {sr[N-2:0], sin} (shift left, insert at LSB).
  - mode=0: sr <= {sin, sr[N-1:1]} (shift right, insert at MSB).
  - When cnt==0, the mode used for this bit and stored for the word is the current msb_first input. msb_first changes mid-word are ignored.
  - cnt increments and wraps from N-1 to 0.
- Word completion (accepted bit with cnt==N-1):
  - The completed word is the shifted value including this bit.
  - If the buffer is free this cycle (q_valid==0, or q_valid && q_ready), then q <= word and q_valid <= 1 on the same edge. q_valid is therefore first visible the cycle after the last bit; latency is 1 cycle.
  - Otherwise the word is discarded, q is unchanged, and overrun <= 1.
  - sr need not be cleared; the next word fully overwrites it.
- Output handshake:
  - q and q_valid are stable while q_valid=1 && q_ready=0.
  - On q_valid && q_ready with no completion the same cycle, q_valid <= 0 and q holds its old value.
  - Completion and drain in the same cycle: buffer reloads, q_valid stays 1, no overrun.
- sync:
  - On sync=1, cnt and sr clear and any partial word is dropped; this does not set overrun.
  - If sin_valid=1 in the same cycle, that bit is accepted as bit 0 of a new word (cnt becomes 1, mode latched from msb_first).
  - sync does not affect q, q_valid or overrun.
- overrun:
  - Set by a dropped word; cleared by clr_ovr.
  - If set and clear occur in the same cycle, set wins.

Test Plan:
1. Reset: drive rst=1 for 2 cycles mid-word (after 2 bits) with q_valid=1 -> q=0, q_valid=0, overrun=0. Then 4 bits 1,0,1,1 (msb_first=1) -> q=4'b1011, showing no leftover partial bits.
2. MSB-first: N=4, q_ready=1, msb_first=1, bits 1,0,1,1 on consecutive cycles -> q=4'hB, q_valid=1 exactly one cycle after the 4th bit, q_valid=0 the following cycle. Repeat with idle gaps between bits -> same result.
3. LSB-first: msb_first=0, bits 1,0,1,1 -> q=4'hD. Toggling msb_first after bit 1 has no effect: q stays 4'hD.
4. Backpressure/overrun: q_ready=0, send 4'hA then 4'h5 (MSB-first) -> q stays 4'hA, q_valid=1, overrun=1 after the 8th bit. Raise q_ready -> q_valid drops with q=4'hA; 4'h5 never appears. Pulse clr_ovr -> overrun=0.
5. Simultaneous drain and completion: q holds 4'hA with q_ready=0; raise q_ready in exactly the cycle the last bit of 4'h3 arrives -> q=4'h3, q_valid stays 1, overrun=0.
6. sync mid-word: MSB-first bits 1,1, then sync=1 with sin_valid=1, sin=0, then bits 1,0,1 -> q=4'h5, no overrun. sync with sin_valid=0 after 3 bits, then 4 new bits 1,1,1,0 -> q=4'hE.

Source files
------------

// File: rtl/deser_shift_rx.sv
// Serial-in, parallel-out receiver: assembles N-bit words MSB- or LSB-first
// and hands each completed word to a single-entry valid/ready output buffer.
module deser_shift_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         msb_first,
  input  logic         sync,
  output logic [N-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         overrun,
  input  logic         clr_ovr
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [N-1:0]   buf_q, buf_d;
  logic           qv_q, qv_d;
  logic           ovr_q, ovr_d;

  // sync acts before the bit of the same cycle, so the bit becomes bit 0.
  logic [N-1:0]   base_sr;
  logic [CW-1:0]  base_cnt;
  logic           eff_mode;
  logic [N-1:0]   shifted;
  logic           last_bit;
  logic           buf_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      buf_q   <= '0;
      qv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
      qv_q    <= qv_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    base_sr  = sync ? '0 : sr_q;
    base_cnt = sync ? '0 : cnt_q;
    eff_mode = (base_cnt == '0) ? msb_first : mode_q;
    shifted  = eff_mode ? {base_sr[N-2:0], sin} : {sin, base_sr[N-1:1]};
    last_bit = sin_valid && (base_cnt == CNT_LAST);
    buf_free = !qv_q || q_ready;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = base_sr;
    cnt_d   = base_cnt;
    mode_d  = eff_mode;
    buf_d   = buf_q;
    qv_d    = qv_q;
    ovr_d   = ovr_q;

    if (sin_valid) begin
      sr_d  = shifted;
      cnt_d = last_bit ? '0 : base_cnt + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (sin_valid && !last_bit) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (sync && !(sin_valid && !last_bit)) state_d = IDLE;
        else if (last_bit)                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (last_bit && buf_free) begin
      buf_d = shifted;
      qv_d  = 1'b1;
    end else if (qv_q && q_ready) begin
      qv_d  = 1'b0;
    end

    // A dropped word takes priority over a simultaneous clear.
    if (last_bit && !buf_free) ovr_d = 1'b1;
    else if (clr_ovr)          ovr_d = 1'b0;
  end

  assign q       = buf_q;
  assign q_valid = qv_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_deser_shift_rx.sv
// Directed bench for deser_shift_rx (N=4) with hand-computed expectations.
module tb_deser_shift_rx;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, sin, sin_valid, msb_first, sync, q_ready, clr_ovr;
  logic [N-1:0] q;
  logic         q_valid, overrun;

  int tests  = 0;
  int failed = 0;

  deser_shift_rx #(.N(N)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .msb_first(msb_first), .sync(sync), .q(q), .q_valid(q_valid),
    .q_ready(q_ready), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock with the current inputs; strobes drop afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sync      = 1'b0;
    clr_ovr   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    sin_valid = 1'b1;
    tick();
  endtask

  // Bits go out in time order w[3], w[2], w[1], w[0].
  task automatic send4(input logic [3:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i]);
      if (gaps && i != 0) tick();
    end
  endtask

  initial begin
    rst = 1'b1; sin = 0; sin_valid = 0; msb_first = 1; sync = 0;
    q_ready = 1; clr_ovr = 0;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    chk("reset_q", q, 0);
    chk("reset_qv", q_valid, 0);
    chk("reset_ovr", overrun, 0);

    // MSB-first, back to back, then with gaps
    msb_first = 1;
    send4(4'b1011, 0);
    chk("msb_q", q, 4'hB);
    chk("msb_qv", q_valid, 1);
    tick();
    chk("msb_drain", q_valid, 0);
    send4(4'b1011, 1);
    chk("msb_gap_q", q, 4'hB);
    chk("msb_gap_qv", q_valid, 1);
    tick();
    chk("msb_gap_drain", q_valid, 0);

    // LSB-first; msb_first toggle mid-word ignored
    msb_first = 0;
    send4(4'b1011, 0);
    chk("lsb_q", q, 4'hD);
    tick();
    send_bit(1);
    msb_first = 1;
    send_bit(0); send_bit(1); send_bit(1);
    chk("lsb_toggle_q", q, 4'hD);
    chk("lsb_toggle_qv", q_valid, 1);
    tick();

    // Backpressure and overrun
    q_ready = 0; msb_first = 1;
    send4(4'hA, 0);
    chk("bp_first_q", q, 4'hA);
    chk("bp_first_ovr", overrun, 0);
    send4(4'h5, 0);
    chk("bp_q_held", q, 4'hA);
    chk("bp_qv", q_valid, 1);
    chk("bp_ovr", overrun, 1);
    q_ready = 1;
    tick();
    chk("bp_drain_qv", q_valid, 0);
    chk("bp_drain_q", q, 4'hA);
    q_ready = 0;
    tick();
    chk("bp_ovr_sticky", overrun, 1);
    clr_ovr = 1;
    tick();
    chk("bp_ovr_clr", overrun, 0);

    // Drain and completion in the same cycle
    send4(4'hA, 0);
    chk("sim_pre_q", q, 4'hA);
    send_bit(0); send_bit(0); send_bit(1);
    q_ready = 1;
    send_bit(1);
    chk("sim_q", q, 4'h3);
    chk("sim_qv", q_valid, 1);
    chk("sim_ovr", overrun, 0);
    tick();
    chk("sim_drain", q_valid, 0);

    // sync with a bit in the same cycle
    send_bit(1); send_bit(1);
    sync = 1;
    send_bit(0);
    send_bit(1); send_bit(0);
    chk("sync_partial_qv", q_valid, 0);
    send_bit(1);
    chk("sync_bit_q", q, 4'h5);
    chk("sync_bit_ovr", overrun, 0);
    tick();

    // sync alone after 3 bits; hold the result for the reset test
    q_ready = 0;
    send_bit(1); send_bit(0); send_bit(1);
    sync = 1;
    tick();
    send4(4'hE, 0);
    chk("sync_only_q", q, 4'hE);
    chk("sync_only_qv", q_valid, 1);
    chk("sync_only_ovr", overrun, 0);

    // Reset mid-word with a buffered word and overrun set
    send4(4'h0, 0);
    chk("pre_rst_ovr", overrun, 1);
    send_bit(1); send_bit(1);
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_mid_q", q, 0);
    chk("rst_mid_qv", q_valid, 0);
    chk("rst_mid_ovr", overrun, 0);
    msb_first = 1;
    send4(4'b1011, 0);
    chk("post_rst_q", q, 4'hB);
    chk("post_rst_qv", q_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
